// File: rtl/writeback_sequencer_if.sv
// Result and register-file write bundle for writeback_sequencer.
// master = result producer / register-file observer, slave = the sequencer.
interface writeback_sequencer_if;
  logic        int_valid;
  logic        int_ready;
  logic [4:0]  int_reg;
  logic [31:0] int_data;

  logic        fp_valid;
  logic        fp_ready;
  logic        fp_double;
  logic [4:0]  fp_reg;
  logic [31:0] fp_data1;
  logic [31:0] fp_data2;

  logic        regWrite;
  logic [4:0]  writeReg;
  logic [31:0] writeData;
  logic        regWritef;
  logic        regDWritef;
  logic [4:0]  writeRegf;
  logic [31:0] writeData1f;
  logic [31:0] writeData2f;
  logic        idle;
  logic        dbl_err;

  modport master (
    output int_valid, int_reg, int_data,
    output fp_valid, fp_double, fp_reg, fp_data1, fp_data2,
    input  int_ready, fp_ready,
    input  regWrite, writeReg, writeData,
    input  regWritef, regDWritef, writeRegf, writeData1f, writeData2f,
    input  idle, dbl_err
  );

  modport slave (
    input  int_valid, int_reg, int_data,
    input  fp_valid, fp_double, fp_reg, fp_data1, fp_data2,
    output int_ready, fp_ready,
    output regWrite, writeReg, writeData,
    output regWritef, regDWritef, writeRegf, writeData1f, writeData2f,
    output idle, dbl_err
  );
endinterface

// File: rtl/writeback_sequencer.sv
// Write-side sequencer for the int/FP register file: two result FIFOs,
// round-robin arbitration, one registered register-file write per cycle.
module writeback_sequencer #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned PTR_W = 2
) (
  input logic                  clk,
  input logic                  rst,
  writeback_sequencer_if.slave bus
);

  localparam logic [PTR_W:0]   FULL_CNT = (PTR_W+1)'(DEPTH);
  localparam logic [PTR_W:0]   CNT_ONE  = (PTR_W+1)'(1);
  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);

  typedef enum logic {LAST_INT, LAST_FP} last_e;

  last_e last_q, last_d;

  // Integer FIFO
  logic [4:0]       ireg_mem [DEPTH];
  logic [31:0]      idat_mem [DEPTH];
  logic [PTR_W-1:0] iwr_q, iwr_d, ird_q, ird_d;
  logic [PTR_W:0]   icnt_q, icnt_d;

  // FP FIFO
  logic             fdbl_mem [DEPTH];
  logic [4:0]       freg_mem [DEPTH];
  logic [31:0]      fd1_mem  [DEPTH];
  logic [31:0]      fd2_mem  [DEPTH];
  logic [PTR_W-1:0] fwr_q, fwr_d, frd_q, frd_d;
  logic [PTR_W:0]   fcnt_q, fcnt_d;

  logic int_push, int_pop, fp_push, fp_pop;
  logic int_ne, fp_ne;

  // Registered register-file outputs
  logic        regWrite_q, regWrite_d;
  logic [4:0]  writeReg_q, writeReg_d;
  logic [31:0] writeData_q, writeData_d;
  logic        regWritef_q, regWritef_d;
  logic        regDWritef_q, regDWritef_d;
  logic [4:0]  writeRegf_q, writeRegf_d;
  logic [31:0] writeData1f_q, writeData1f_d;
  logic [31:0] writeData2f_q, writeData2f_d;
  logic        dbl_err_q, dbl_err_d;

  // Head entries
  logic [4:0]  ih_reg;
  logic [31:0] ih_dat;
  logic        fh_dbl;
  logic [4:0]  fh_reg;
  logic [31:0] fh_d1, fh_d2;

  assign ih_reg = ireg_mem[ird_q];
  assign ih_dat = idat_mem[ird_q];
  assign fh_dbl = fdbl_mem[frd_q];
  assign fh_reg = freg_mem[frd_q];
  assign fh_d1  = fd1_mem[frd_q];
  assign fh_d2  = fd2_mem[frd_q];

  // Ready depends only on registered occupancy, so a full FIFO refuses a push
  // even in the cycle it is being popped.
  assign bus.int_ready = (icnt_q != FULL_CNT);
  assign bus.fp_ready  = (fcnt_q != FULL_CNT);
  assign int_push      = bus.int_valid && (icnt_q != FULL_CNT);
  assign fp_push       = bus.fp_valid  && (fcnt_q != FULL_CNT);
  assign int_ne        = (icnt_q != '0);
  assign fp_ne         = (fcnt_q != '0);

  // Arbiter state register: which channel received the previous grant
  always_ff @(posedge clk or posedge rst) begin
    if (rst) last_q <= LAST_FP;
    else     last_q <= last_d;
  end

  // Arbiter next state: remember the channel granted this cycle
  always_comb begin
    last_d = last_q;
    if (int_pop)     last_d = LAST_INT;
    else if (fp_pop) last_d = LAST_FP;
  end

  // Arbiter outputs: serve the lone non-empty FIFO, else the one not served last
  always_comb begin
    int_pop = 1'b0;
    fp_pop  = 1'b0;
    if (int_ne && (!fp_ne || last_q == LAST_FP)) int_pop = 1'b1;
    else if (fp_ne)                              fp_pop  = 1'b1;
  end

  // FIFO pointer and occupancy next state
  always_comb begin
    iwr_d  = int_push ? iwr_q + PTR_ONE : iwr_q;
    ird_d  = int_pop  ? ird_q + PTR_ONE : ird_q;
    fwr_d  = fp_push  ? fwr_q + PTR_ONE : fwr_q;
    frd_d  = fp_pop   ? frd_q + PTR_ONE : frd_q;
    icnt_d = icnt_q;
    fcnt_d = fcnt_q;
    if (int_push && !int_pop)      icnt_d = icnt_q + CNT_ONE;
    else if (!int_push && int_pop) icnt_d = icnt_q - CNT_ONE;
    if (fp_push && !fp_pop)        fcnt_d = fcnt_q + CNT_ONE;
    else if (!fp_push && fp_pop)   fcnt_d = fcnt_q - CNT_ONE;
  end

  // FIFO pointer and occupancy registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      iwr_q  <= '0;
      ird_q  <= '0;
      icnt_q <= '0;
      fwr_q  <= '0;
      frd_q  <= '0;
      fcnt_q <= '0;
    end else begin
      iwr_q  <= iwr_d;
      ird_q  <= ird_d;
      icnt_q <= icnt_d;
      fwr_q  <= fwr_d;
      frd_q  <= frd_d;
      fcnt_q <= fcnt_d;
    end
  end

  // FIFO storage; contents are only meaningful behind the occupancy count
  always_ff @(posedge clk) begin
    if (int_push) begin
      ireg_mem[iwr_q] <= bus.int_reg;
      idat_mem[iwr_q] <= bus.int_data;
    end
    if (fp_push) begin
      fdbl_mem[fwr_q] <= bus.fp_double;
      freg_mem[fwr_q] <= bus.fp_reg;
      fd1_mem[fwr_q]  <= bus.fp_data1;
      fd2_mem[fwr_q]  <= bus.fp_data2;
    end
  end

  // Decode the popped entry into next register-file write; discarded targets
  // consume the slot without a strobe and leave address/data untouched
  always_comb begin
    regWrite_d    = 1'b0;
    regWritef_d   = 1'b0;
    regDWritef_d  = 1'b0;
    writeReg_d    = writeReg_q;
    writeData_d   = writeData_q;
    writeRegf_d   = writeRegf_q;
    writeData1f_d = writeData1f_q;
    writeData2f_d = writeData2f_q;
    dbl_err_d     = dbl_err_q;
    if (int_pop && ih_reg != 5'd0) begin
      regWrite_d  = 1'b1;
      writeReg_d  = ih_reg;
      writeData_d = ih_dat;
    end
    if (fp_pop) begin
      if (fh_dbl) begin
        if (fh_reg == 5'd0 || fh_reg == 5'd31) begin
          dbl_err_d = 1'b1;
        end else begin
          regDWritef_d  = 1'b1;
          writeRegf_d   = fh_reg;
          writeData1f_d = fh_d1;
          writeData2f_d = fh_d2;
        end
      end else if (fh_reg != 5'd0) begin
        regWritef_d   = 1'b1;
        writeRegf_d   = fh_reg;
        writeData1f_d = fh_d1;
      end
    end
  end

  // Register-file output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      regWrite_q    <= 1'b0;
      writeReg_q    <= '0;
      writeData_q   <= '0;
      regWritef_q   <= 1'b0;
      regDWritef_q  <= 1'b0;
      writeRegf_q   <= '0;
      writeData1f_q <= '0;
      writeData2f_q <= '0;
      dbl_err_q     <= 1'b0;
    end else begin
      regWrite_q    <= regWrite_d;
      writeReg_q    <= writeReg_d;
      writeData_q   <= writeData_d;
      regWritef_q   <= regWritef_d;
      regDWritef_q  <= regDWritef_d;
      writeRegf_q   <= writeRegf_d;
      writeData1f_q <= writeData1f_d;
      writeData2f_q <= writeData2f_d;
      dbl_err_q     <= dbl_err_d;
    end
  end

  assign bus.regWrite    = regWrite_q;
  assign bus.writeReg    = writeReg_q;
  assign bus.writeData   = writeData_q;
  assign bus.regWritef   = regWritef_q;
  assign bus.regDWritef  = regDWritef_q;
  assign bus.writeRegf   = writeRegf_q;
  assign bus.writeData1f = writeData1f_q;
  assign bus.writeData2f = writeData2f_q;
  assign bus.dbl_err     = dbl_err_q;
  assign bus.idle        = !int_ne && !fp_ne &&
                           !(regWrite_q || regWritef_q || regDWritef_q);

endmodule

// File: tb/tb_writeback_sequencer.sv
// Randomized and directed bench for writeback_sequencer against a queue-based model.
module tb_writeback_sequencer;
  localparam int unsigned DEPTH = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  writeback_sequencer_if bus();

  writeback_sequencer #(.DEPTH(DEPTH), .PTR_W(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic [4:0]  r;
    logic [31:0] d;
  } int_e;

  typedef struct {
    bit          dbl;
    logic [4:0]  r;
    logic [31:0] d1;
    logic [31:0] d2;
  } fp_e;

  int_e m_int[$];
  fp_e  m_fp[$];
  bit   m_last_int;   // 1: previous grant went to int
  bit   m_dbl_err;

  int checks   = 0;
  int failures = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  // One clock: drive inputs, check ready, advance model across the edge, check outputs.
  task automatic step(input bit iv, input logic [4:0] ir, input logic [31:0] id,
                      input bit fv, input bit fdb, input logic [4:0] fr,
                      input logic [31:0] f1, input logic [31:0] f2);
    bit acc_i, acc_f, e_rw, e_rwf, e_rdwf;
    logic [4:0]  e_wr, e_wrf;
    logic [31:0] e_wd, e_d1, e_d2;
    int_e ie;
    fp_e  fe;
    bus.int_valid = iv;  bus.int_reg = ir;  bus.int_data = id;
    bus.fp_valid  = fv;  bus.fp_double = fdb; bus.fp_reg = fr;
    bus.fp_data1  = f1;  bus.fp_data2 = f2;
    acc_i = iv && (m_int.size() < DEPTH);
    acc_f = fv && (m_fp.size() < DEPTH);
    check_eq("int_ready", bus.int_ready, m_int.size() < DEPTH);
    check_eq("fp_ready",  bus.fp_ready,  m_fp.size()  < DEPTH);
    @(posedge clk);
    e_rw = 0; e_rwf = 0; e_rdwf = 0;
    e_wr = '0; e_wd = '0; e_wrf = '0; e_d1 = '0; e_d2 = '0;
    if (m_int.size() > 0 && (m_fp.size() == 0 || !m_last_int)) begin
      ie = m_int.pop_front();
      m_last_int = 1;
      if (ie.r != 0) begin e_rw = 1; e_wr = ie.r; e_wd = ie.d; end
    end else if (m_fp.size() > 0) begin
      fe = m_fp.pop_front();
      m_last_int = 0;
      if (fe.dbl) begin
        if (fe.r == 0 || fe.r == 31) m_dbl_err = 1;
        else begin e_rdwf = 1; e_wrf = fe.r; e_d1 = fe.d1; e_d2 = fe.d2; end
      end else if (fe.r != 0) begin
        e_rwf = 1; e_wrf = fe.r; e_d1 = fe.d1;
      end
    end
    if (acc_i) m_int.push_back('{r: ir, d: id});
    if (acc_f) m_fp.push_back('{dbl: fdb, r: fr, d1: f1, d2: f2});
    #1;
    check_eq("regWrite",   bus.regWrite,   e_rw);
    check_eq("regWritef",  bus.regWritef,  e_rwf);
    check_eq("regDWritef", bus.regDWritef, e_rdwf);
    check_eq("onehot", $countones({bus.regWrite, bus.regWritef, bus.regDWritef}) <= 1, 1);
    if (e_rw) begin
      check_eq("writeReg",  bus.writeReg,  e_wr);
      check_eq("writeData", bus.writeData, e_wd);
    end
    if (e_rwf || e_rdwf) begin
      check_eq("writeRegf",   bus.writeRegf,   e_wrf);
      check_eq("writeData1f", bus.writeData1f, e_d1);
    end
    if (e_rdwf) check_eq("writeData2f", bus.writeData2f, e_d2);
    check_eq("idle", bus.idle, m_int.size() == 0 && m_fp.size() == 0 && !e_rw && !e_rwf && !e_rdwf);
    check_eq("dbl_err", bus.dbl_err, m_dbl_err);
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) step(0, 5'd0, 32'd0, 0, 0, 5'd0, 32'd0, 32'd0);
  endtask

  // Asynchronous reset in the middle of a cycle, with entries queued.
  task automatic mid_reset();
    #2;
    rst = 1'b1;
    bus.int_valid = 1'b0;
    bus.fp_valid  = 1'b0;
    #1;
    check_eq("rst_regWrite",   bus.regWrite,   0);
    check_eq("rst_regWritef",  bus.regWritef,  0);
    check_eq("rst_regDWritef", bus.regDWritef, 0);
    check_eq("rst_int_ready",  bus.int_ready,  1);
    check_eq("rst_fp_ready",   bus.fp_ready,   1);
    check_eq("rst_idle",       bus.idle,       1);
    check_eq("rst_dbl_err",    bus.dbl_err,    0);
    m_int.delete();
    m_fp.delete();
    m_last_int = 0;
    m_dbl_err  = 0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  function automatic logic [4:0] rand_reg();
    int unsigned k = $urandom_range(0, 7);
    if (k == 0) return 5'd0;
    if (k == 1) return 5'd31;
    return 5'($urandom_range(1, 30));
  endfunction

  initial begin
    rst = 1'b1;
    bus.int_valid = 0; bus.int_reg = '0; bus.int_data = '0;
    bus.fp_valid  = 0; bus.fp_double = 0; bus.fp_reg = '0;
    bus.fp_data1  = '0; bus.fp_data2 = '0;
    m_last_int = 0;
    m_dbl_err  = 0;
    #1;
    check_eq("por_regWrite",  bus.regWrite,  0);
    check_eq("por_regWritef", bus.regWritef, 0);
    check_eq("por_int_ready", bus.int_ready, 1);
    check_eq("por_fp_ready",  bus.fp_ready,  1);
    check_eq("por_idle",      bus.idle,      1);
    check_eq("por_dbl_err",   bus.dbl_err,   0);
    @(negedge clk);
    rst = 1'b0;

    // Int stream, regs 1..4, data A0..A3
    for (int i = 0; i < 4; i++)
      step(1, 5'(i + 1), 32'hA0 + 32'(i), 0, 0, 5'd0, 32'd0, 32'd0);
    idle_cycles(3);

    // Contention: both channels two entries
    for (int i = 0; i < 2; i++)
      step(1, 5'(10 + i), 32'hB0 + 32'(i), 1, 0, 5'(20 + i), 32'hC0 + 32'(i), 32'd0);
    idle_cycles(5);

    // Doubles: legal reg 6, then illegal reg 31
    step(0, 5'd0, 32'd0, 1, 1, 5'd6, 32'h3FF00000, 32'h0);
    idle_cycles(2);
    step(0, 5'd0, 32'd0, 1, 1, 5'd31, 32'h11111111, 32'h22222222);
    idle_cycles(4);
    check_eq("dbl_sticky", bus.dbl_err, 1);

    // Zero targets
    step(1, 5'd0, 32'hDEAD, 1, 0, 5'd0, 32'hBEEF, 32'd0);
    idle_cycles(4);

    // Full boundary: continuous offers on both channels fill both FIFOs
    for (int i = 0; i < 14; i++)
      step(1, 5'(1 + i), 32'hE00 + 32'(i), 1, 0, 5'(1 + i), 32'hF00 + 32'(i), 32'd0);
    idle_cycles(10);

    // Reset mid-burst with entries queued
    for (int i = 0; i < 3; i++)
      step(1, 5'd3, 32'h55 + 32'(i), 1, 1, 5'd4, 32'h66, 32'h77);
    mid_reset();
    idle_cycles(4);

    // Random traffic with one reset in the middle
    for (int i = 0; i < 500; i++) begin
      if (i == 250) mid_reset();
      step($urandom_range(0, 9) < 6, rand_reg(), $urandom(),
           $urandom_range(0, 9) < 6, $urandom_range(0, 1) == 1, rand_reg(),
           $urandom(), $urandom());
    end
    idle_cycles(12);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
